hazard_ctrl_gen: RTL and testbench

// Second-generation pipeline hazard controller for the 5-stage MIPS core (FE/DE/EX/ME/WB).

---
 rtl/hazard_ctrl_gen.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_hazard_ctrl_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_gen.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_gen
// Pipeline hazard controller for the 5-stage core (FE/DE/EX/ME/WB).
// Drives the per-stage register enables, the bubble-insert flushes and the
// PC-select mux. Inputs are cache hits, load-use dependencies, jumps and
// branches.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, two saturating performance counters are added.
//   stall_cnt counts cycles with pc_en=0.
//   flush_cnt counts cycles with any flush asserted.
//   When undefined, those ports and registers do not exist.
//
// Parameters
//   REG_AW   register-address width
//   LINK_REG register written by jal; a load into it stalls a following jr
//   BR_IN_EX 1: branch resolved in EX from the registered pcsrc
//            0: branch resolved in DE from the live de_pcsrc
//   TMO_W    memory-wait watchdog width; timeout after 2**TMO_W-1 wait cycles
//   PERF_W   performance counter width
//
// Ports
//   CLK, RST                        clock (rising edge), async active-high reset
//   ihit, dhit                      icache / dcache hit this cycle
//   me_ldst                         ME stage holds lw/sw
//   ex_ren, ex_wen                  EX stage holds a load / a store
//   ex_rdst, me_rdst                EX / ME destination registers
//   de_rs, de_rt                    DE source registers
//   de_pcsrc                        0 seq, 1 jr, 2 j/jal, 3 beq, 4 bne
//   br_equal                        comparator result for the resolving branch
//   pc_en .. wb_en                  stage register enables
//   de_flush, ex_flush, me_flush    stage bubble insert
//   pc_sel                          0 pc+4, 1 jr, 2 jump, 3 branch
//   mem_timeout                     sticky watchdog flag, cleared only by RST
//   fsm_state                       debug view of the wait FSM (0 RUN,
//                                   1 MEM_WAIT, 2 FETCH_WAIT)
//   stall_cnt, flush_cnt            perf counters (HAZARD_PERF_CNT_EN only)
//
// Handshake note: there is no valid/ready pair here. A stage advances in a
// cycle exactly when its enable is 1 at the rising edge. A flush replaces
// the stage contents with a bubble on that same edge.
// ----------------------------------------------------------------------------
module hazard_ctrl_gen #(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter int BR_IN_EX = 1,
    parameter int TMO_W    = 8,
    parameter int PERF_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              me_ldst,
    input  logic              ex_ren,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_rdst,
    input  logic [REG_AW-1:0] me_rdst,
    input  logic [REG_AW-1:0] de_rs,
    input  logic [REG_AW-1:0] de_rt,
    input  logic [2:0]        de_pcsrc,
    input  logic              br_equal,
    output logic              pc_en,
    output logic              de_en,
    output logic              ex_en,
    output logic              me_en,
    output logic              wb_en,
    output logic              de_flush,
    output logic              ex_flush,
    output logic              me_flush,
    output logic [1:0]        pc_sel,
    output logic              mem_timeout,
    output logic [1:0]        fsm_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    localparam logic [2:0] PCSRC_JR  = 3'd1;
    localparam logic [2:0] PCSRC_JMP = 3'd2;
    localparam logic [2:0] PCSRC_BEQ = 3'd3;
    localparam logic [2:0] PCSRC_BNE = 3'd4;

    localparam logic [1:0] SEL_PC4 = 2'd0;
    localparam logic [1:0] SEL_JR  = 2'd1;
    localparam logic [1:0] SEL_JMP = 2'd2;
    localparam logic [1:0] SEL_BR  = 2'd3;

    localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);
    localparam logic [TMO_W-1:0]  WD_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_FETCH_WAIT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       br_pcsrc;
    logic [TMO_W-1:0] wd_cnt, wd_nxt, wd_inc;
    logic             tmo_set;
    logic             fw_entry;

    logic [2:0] br_src;
    logic       br_taken;
    logic       raw_haz;
    logic       link_haz;
    logic       ldst_hit;

    // me_rdst is part of the stage interface but carries no hazard here.
    // Any load in ME is handled by the wait FSM, not by forwarding checks.
    logic       me_rdst_unused;
    assign me_rdst_unused = ^me_rdst;

    // --------------------------------------------------------------------
    // Hazard detection
    // --------------------------------------------------------------------
    // A nonzero destination is required. That alone keeps register 0 out
    // of every match, because equality with a nonzero rdst implies a
    // nonzero source.
    assign raw_haz  = (ex_ren | ex_wen) && (ex_rdst != '0) &&
                      ((ex_rdst == de_rs) || (ex_rdst == de_rt));
    assign link_haz = ex_ren && (LINK_ADDR != '0) && (ex_rdst == LINK_ADDR) &&
                      (de_pcsrc == PCSRC_JR);

    // In EX mode the branch type is the one latched when the branch left DE.
    assign br_src   = (BR_IN_EX != 0) ? br_pcsrc : de_pcsrc;
    assign br_taken = ((br_src == PCSRC_BEQ) &&  br_equal) ||
                      ((br_src == PCSRC_BNE) && !br_equal);

    assign ldst_hit = me_ldst && ihit && dhit;

    assign wd_inc   = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

    // --------------------------------------------------------------------
    // Next state and outputs
    // --------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wd_nxt    = wd_cnt;
        tmo_set   = 1'b0;
        pc_en     = 1'b0;
        de_en     = 1'b0;
        ex_en     = 1'b0;
        me_en     = 1'b0;
        wb_en     = 1'b0;
        de_flush  = 1'b0;
        ex_flush  = 1'b0;
        me_flush  = 1'b0;
        pc_sel    = SEL_PC4;

        case (state)
            ST_RUN: begin
                if (me_ldst && !dhit) begin
                    state_nxt = ST_MEM_WAIT;
                end else if (me_ldst && dhit && !ihit) begin
                    state_nxt = ST_FETCH_WAIT;
                end

                if (ldst_hit) begin
                    // A memory op that hits both caches takes priority over
                    // every DE/EX hazard.
                    pc_en = ihit;
                    de_en = ihit;
                    ex_en = ihit;
                    me_en = ihit;
                    wb_en = ihit;
                end else if (raw_haz || link_haz) begin
                    // Hold FE/DE and insert a bubble into EX so the
                    // producer drains one stage ahead.
                    me_en    = ihit;
                    wb_en    = ihit;
                    ex_flush = ihit;
                end else if (br_taken) begin
                    pc_sel   = SEL_BR;
                    pc_en    = ihit;
                    me_en    = ihit;
                    wb_en    = ihit;
                    de_flush = ihit;
                    ex_flush = (BR_IN_EX != 0) ? ihit : 1'b0;
                end else if (de_pcsrc == PCSRC_JMP) begin
                    pc_sel   = SEL_JMP;
                    pc_en    = ihit;
                    ex_en    = ihit;
                    me_en    = ihit;
                    wb_en    = ihit;
                    de_flush = ihit;
                end else if (de_pcsrc == PCSRC_JR) begin
                    pc_sel   = SEL_JR;
                    pc_en    = ihit;
                    ex_en    = ihit;
                    me_en    = ihit;
                    wb_en    = ihit;
                    de_flush = ihit;
                end else begin
                    pc_en = ihit;
                    de_en = ihit;
                    ex_en = ihit;
                    me_en = ihit;
                    wb_en = ihit;
                end
            end

            ST_MEM_WAIT: begin
                // The whole pipe is frozen while the dcache refills.
                if (dhit && ihit) begin
                    state_nxt = ST_RUN;
                    wd_nxt    = '0;
                end else if (dhit) begin
                    state_nxt = ST_FETCH_WAIT;
                    wd_nxt    = '0;
                end else begin
                    wd_nxt  = wd_inc;
                    tmo_set = (wd_inc == WD_MAX);
                end
            end

            ST_FETCH_WAIT: begin
                // The load finished in ME. Retire it into WB once, then keep
                // a bubble in ME until the icache delivers.
                wb_en    = fw_entry;
                me_flush = fw_entry;
                if (ihit) begin
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // --------------------------------------------------------------------
    // State registers
    // --------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_RUN;
            br_pcsrc    <= 3'd0;
            wd_cnt      <= '0;
            mem_timeout <= 1'b0;
            fw_entry    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wd_cnt   <= wd_nxt;
            fw_entry <= (state_nxt == ST_FETCH_WAIT) && (state != ST_FETCH_WAIT);
            if (tmo_set) begin
                mem_timeout <= 1'b1;
            end
            // Without ihit the fetch is stalled. A pending branch type must
            // then survive, so it is only replaced on a hit.
            if (ihit) begin
                br_pcsrc <= de_pcsrc;
            end
        end
    end

    assign fsm_state = state;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != PERF_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((de_flush || ex_flush || me_flush) && (flush_cnt != PERF_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
module tb_hazard_ctrl_gen;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, me_ldst, ex_ren, ex_wen, br_equal;
    logic [4:0] ex_rdst, me_rdst, de_rs, de_rt;
    logic [2:0] de_pcsrc;
    logic       pc_en, de_en, ex_en, me_en, wb_en;
    logic       de_flush, ex_flush, me_flush;
    logic [1:0] pc_sel;
    logic       mem_timeout;
    logic [1:0] fsm_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // {pc_en,de_en,ex_en,me_en,wb_en, de_flush,ex_flush,me_flush, pc_sel}
    logic [9:0] ctl;
    assign ctl = {pc_en, de_en, ex_en, me_en, wb_en, de_flush, ex_flush, me_flush, pc_sel};

    hazard_ctrl_gen #(
        .REG_AW(5), .LINK_REG(31), .BR_IN_EX(1), .TMO_W(4), .PERF_W(32)
    ) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .me_ldst(me_ldst),
        .ex_ren(ex_ren), .ex_wen(ex_wen), .ex_rdst(ex_rdst), .me_rdst(me_rdst),
        .de_rs(de_rs), .de_rt(de_rt), .de_pcsrc(de_pcsrc), .br_equal(br_equal),
        .pc_en(pc_en), .de_en(de_en), .ex_en(ex_en), .me_en(me_en), .wb_en(wb_en),
        .de_flush(de_flush), .ex_flush(ex_flush), .me_flush(me_flush),
        .pc_sel(pc_sel), .mem_timeout(mem_timeout), .fsm_state(fsm_state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, required finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        ihit = 1'b1; dhit = 1'b1; me_ldst = 1'b0; ex_ren = 1'b0; ex_wen = 1'b0;
        ex_rdst = 5'd0; me_rdst = 5'd0; de_rs = 5'd0; de_rt = 5'd0;
        de_pcsrc = 3'd0; br_equal = 1'b0;
    endtask

    // Idle for one edge so the latched branch type is back to sequential.
    task automatic settle_idle();
        drive_idle();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0] exp;
        drive_idle();
        br_equal = 1'b1;
        RST = 1'b1;
        tick();
        tick();
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL reset_ctl: got %b want %b", ctl, exp); end
        n_checks++;
        if (fsm_state !== 2'd0) begin n_fails++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        n_checks++;
        if (mem_timeout !== 1'b0) begin n_fails++; $display("FAIL reset_tmo: got %b want 0", mem_timeout); end
        RST = 1'b0;
        tick();
        // br_pcsrc was reset to 0, so a br_equal=1 must not select the branch.
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL post_reset_ctl: got %b want %b", ctl, exp); end
    endtask

    task automatic test_load_use();
        logic [9:0] exp;
        settle_idle();
        ex_ren = 1'b1; ex_rdst = 5'd5; de_rs = 5'd5; de_rt = 5'd9;
        #1;
        exp = 10'b00011_010_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL load_use_rs: got %b want %b", ctl, exp); end
        tick();
        ex_ren = 1'b0;
        #1;
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL load_use_release: got %b want %b", ctl, exp); end
        // Store producer matching rt while the icache misses.
        ex_wen = 1'b1; ex_rdst = 5'd7; de_rs = 5'd1; de_rt = 5'd7; ihit = 1'b0;
        #1;
        exp = 10'b00000_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL store_rt_nohit: got %b want %b", ctl, exp); end
        ihit = 1'b1;
        #1;
        exp = 10'b00011_010_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL store_rt_hit: got %b want %b", ctl, exp); end
    endtask

    task automatic test_zero_reg();
        logic [9:0] exp;
        settle_idle();
        ex_ren = 1'b1; ex_rdst = 5'd0; de_rs = 5'd0; de_rt = 5'd0;
        #1;
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL zero_reg: got %b want %b", ctl, exp); end
        ex_rdst = 5'd3; de_rs = 5'd4; de_rt = 5'd6;
        #1;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL no_match: got %b want %b", ctl, exp); end
    endtask

    task automatic test_jr_link();
        logic [9:0] exp;
        settle_idle();
        ex_ren = 1'b1; ex_rdst = 5'd31; de_pcsrc = 3'd1; de_rs = 5'd2; de_rt = 5'd0;
        #1;
        exp = 10'b00011_010_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL jr_link_stall: got %b want %b", ctl, exp); end
        ex_ren = 1'b0;
        #1;
        exp = 10'b10111_100_01;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL jr_plain: got %b want %b", ctl, exp); end
        // A store into the link register does not create a jr dependency.
        ex_wen = 1'b1;
        #1;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL jr_store_link: got %b want %b", ctl, exp); end
    endtask

    task automatic test_jump();
        logic [9:0] exp;
        settle_idle();
        de_pcsrc = 3'd2;
        #1;
        exp = 10'b10111_100_10;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL jump_hit: got %b want %b", ctl, exp); end
        ihit = 1'b0;
        #1;
        exp = 10'b00000_000_10;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL jump_nohit: got %b want %b", ctl, exp); end
    endtask

    task automatic test_branch();
        logic [9:0] exp;
        // beq: type latched one cycle, then resolved in EX.
        settle_idle();
        de_pcsrc = 3'd3;
        #1;
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL beq_in_de: got %b want %b", ctl, exp); end
        tick();
        de_pcsrc = 3'd0; br_equal = 1'b0;
        #1;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL beq_not_taken: got %b want %b", ctl, exp); end
        br_equal = 1'b1;
        #1;
        exp = 10'b10011_110_11;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL beq_taken: got %b want %b", ctl, exp); end
        // bne taken on unequal.
        settle_idle();
        de_pcsrc = 3'd4;
        tick();
        de_pcsrc = 3'd0; br_equal = 1'b0;
        #1;
        exp = 10'b10011_110_11;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL bne_taken: got %b want %b", ctl, exp); end
        br_equal = 1'b1;
        #1;
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL bne_not_taken: got %b want %b", ctl, exp); end
        // Branch held across an icache stall.
        settle_idle();
        de_pcsrc = 3'd3;
        tick();
        de_pcsrc = 3'd0; br_equal = 1'b1; ihit = 1'b0;
        #1;
        exp = 10'b00000_000_11;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL br_stalled: got %b want %b", ctl, exp); end
        tick();
        ihit = 1'b1;
        #1;
        exp = 10'b10011_110_11;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL br_held: got %b want %b", ctl, exp); end
    endtask

    task automatic test_mem_miss();
        logic [9:0] exp;
        settle_idle();
        // A hitting memory op overrides a load-use hazard.
        me_ldst = 1'b1; ex_ren = 1'b1; ex_rdst = 5'd5; de_rs = 5'd5;
        #1;
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL ldst_hit_priority: got %b want %b", ctl, exp); end
        ex_ren = 1'b0; dhit = 1'b0;
        tick();
        n_checks++;
        if (fsm_state !== 2'd1) begin n_fails++; $display("FAIL miss_enter: got %0d want 1", fsm_state); end
        exp = 10'b00000_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL miss_frozen: got %b want %b", ctl, exp); end
        tick();
        tick();
        n_checks++;
        if (fsm_state !== 2'd1) begin n_fails++; $display("FAIL miss_hold: got %0d want 1", fsm_state); end
        dhit = 1'b1; ihit = 1'b0;
        #1;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL miss_exit_cycle: got %b want %b", ctl, exp); end
        tick();
        n_checks++;
        if (fsm_state !== 2'd2) begin n_fails++; $display("FAIL fetch_wait_enter: got %0d want 2", fsm_state); end
        exp = 10'b00001_001_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL fetch_wait_retire: got %b want %b", ctl, exp); end
        me_ldst = 1'b0;
        tick();
        exp = 10'b00000_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL fetch_wait_second: got %b want %b", ctl, exp); end
        ihit = 1'b1;
        tick();
        n_checks++;
        if (fsm_state !== 2'd0) begin n_fails++; $display("FAIL fetch_wait_exit: got %0d want 0", fsm_state); end
        exp = 10'b11111_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL run_after_wait: got %b want %b", ctl, exp); end
        // Direct RUN -> FETCH_WAIT on dcache hit with icache miss.
        me_ldst = 1'b1; ihit = 1'b0;
        #1;
        exp = 10'b00000_000_00;
        n_checks++;
        if (ctl !== exp) begin n_fails++; $display("FAIL ldst_icache_miss: got %b want %b", ctl, exp); end
        tick();
        me_ldst = 1'b0;
        #1;
        exp = 10'b00001_001_00;
        n_checks++;
        if (fsm_state !== 2'd2 || ctl !== exp) begin
            n_fails++;
            $display("FAIL direct_fetch_wait: got st=%0d ctl=%b want st=2 ctl=%b", fsm_state, ctl, exp);
        end
        ihit = 1'b1;
        tick();
        n_checks++;
        if (mem_timeout !== 1'b0) begin n_fails++; $display("FAIL miss_no_tmo: got %b want 0", mem_timeout); end
    endtask

    task automatic test_watchdog();
        settle_idle();
        me_ldst = 1'b1; dhit = 1'b0;
        tick();
        repeat (14) tick();
        n_checks++;
        if (mem_timeout !== 1'b0) begin n_fails++; $display("FAIL wd_early: got %b want 0", mem_timeout); end
        tick();
        n_checks++;
        if (mem_timeout !== 1'b1) begin n_fails++; $display("FAIL wd_fire: got %b want 1", mem_timeout); end
        dhit = 1'b1;
        tick();
        me_ldst = 1'b0;
        tick();
        n_checks++;
        if (mem_timeout !== 1'b1 || fsm_state !== 2'd0) begin
            n_fails++;
            $display("FAIL wd_sticky: got tmo=%b st=%0d want tmo=1 st=0", mem_timeout, fsm_state);
        end
    endtask

    task automatic test_reset_mid_wait();
        settle_idle();
        me_ldst = 1'b1; dhit = 1'b0;
        repeat (6) tick();
        RST = 1'b1;
        #1;
        n_checks++;
        if (fsm_state !== 2'd0 || mem_timeout !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_mid_wait: got st=%0d tmo=%b want st=0 tmo=0", fsm_state, mem_timeout);
        end
        tick();
        RST = 1'b0;
        // Counter must restart from zero: 15 wait edges needed again.
        tick();
        repeat (14) tick();
        n_checks++;
        if (mem_timeout !== 1'b0) begin n_fails++; $display("FAIL wd_cleared: got %b want 0", mem_timeout); end
        drive_idle();
        tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        drive_idle();
        ihit = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fails++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        repeat (4) tick();
        ihit = 1'b1; de_pcsrc = 3'd2;
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (stall_cnt !== 32'd4 || flush_cnt !== 32'd1) begin
            n_fails++;
            $display("FAIL perf_counts: got stall=%0d flush=%0d want 4/1", stall_cnt, flush_cnt);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        RST = 1'b1;
        drive_idle();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_jr_link();
        test_jump();
        test_branch();
        test_mem_miss();
        test_watchdog();
        test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
